// File: rtl/unified_mem_responder_pkg.sv
// Shared types for the unified instruction/data memory responder.
// Holds the FSM states, request kinds and word geometry used by the top and its interface users.
package mem_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   typedef enum logic [1:0] {
      REQ_RD,
      REQ_WR,
      REQ_ERR
   } req_kind_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/unified_mem_responder_if.sv
// Memory port between the multicycle datapath (master) and the unified memory (slave).
// Level requests in, registered read data and one-cycle ready/error pulses out.
interface unified_mem_responder_if;

   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        mem_err;
   logic        busy;

   modport master (
      output mem_addr, mem_wdata, mem_read, mem_write,
      input  mem_rdata, mem_ready, mem_err, busy
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_read, mem_write,
      output mem_rdata, mem_ready, mem_err, busy
   );

endinterface

// File: rtl/unified_mem_responder.sv
// Word-addressed unified memory with configurable read/write latency and illegal-request flagging.
// Latency: ready sampled LATENCY edges after acceptance; no backpressure, one access in flight.
module unified_mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH         = 256,
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_LATENCY = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   unified_mem_responder_if.slave   bus
);

   localparam int IDX_W   = $clog2(DEPTH);
   localparam int MAX_LAT = max_int(READ_LATENCY, WRITE_LATENCY);
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam int LSB_W   = $clog2(WORD_BYTES);

   localparam logic [CNT_W-1:0] RD_LAT_M1 = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_LAT_M1 = CNT_W'(WRITE_LATENCY - 1);

   logic [31:0] mem_array [DEPTH];

   state_e           state_q, state_d;
   req_kind_e        kind_q, kind_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             ready_q, ready_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] lat_m1;
   logic             mem_we;

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      err_d   = 1'b0;
      mem_we  = 1'b0;
      lat_m1  = RD_LAT_M1;

      case (state_q)
         IDLE: begin
            if (bus.mem_read || bus.mem_write) begin
               idx_d   = bus.mem_addr[IDX_W+LSB_W-1:LSB_W];
               wdata_d = bus.mem_wdata;
               if ((bus.mem_read && bus.mem_write) ||
                   (bus.mem_addr[LSB_W-1:0] != '0) ||
                   (bus.mem_addr[31:IDX_W+LSB_W] != '0))
                  kind_d = REQ_ERR;
               else if (bus.mem_write)
                  kind_d = REQ_WR;
               else
                  kind_d = REQ_RD;
               // An illegal request still burns the latency of the access it looked like.
               lat_m1 = (bus.mem_write && !bus.mem_read) ? WR_LAT_M1 : RD_LAT_M1;
               if (lat_m1 == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = BUSY;
                  cnt_d   = lat_m1;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Commit happens only on the edge that enters DONE, so a reset in BUSY drops the write.
      if (state_q != DONE && state_d == DONE) begin
         ready_d = 1'b1;
         err_d   = (kind_d == REQ_ERR);
         if (kind_d == REQ_RD)
            rdata_d = mem_array[idx_d];
         mem_we  = (kind_d == REQ_WR) && rst_n;
      end

      busy_d = (state_d == BUSY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         kind_q  <= REQ_RD;
         idx_q   <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem_array[idx_d] <= wdata_d;
   end

   assign bus.mem_rdata = rdata_q;
   assign bus.mem_ready = ready_q;
   assign bus.mem_err   = err_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Scoreboard bench: two responders (RL=2/WL=1 and RL=3/WL=3) driven with directed accesses.
// Drivers push expected read data/error per access; per-instance monitors pop on each ready pulse.
module tb_unified_mem_responder;
   import mem_pkg::*;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;
   exp_t q_a[$];
   exp_t q_b[$];

   unified_mem_responder_if ifa();
   unified_mem_responder_if ifb();

   unified_mem_responder #(.DEPTH(256), .READ_LATENCY(2), .WRITE_LATENCY(1)) u_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa)
   );

   unified_mem_responder #(.DEPTH(256), .READ_LATENCY(3), .WRITE_LATENCY(3)) u_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_req(input bit sel, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata);
      if (sel) begin
         ifb.mem_read = rd; ifb.mem_write = wr; ifb.mem_addr = addr; ifb.mem_wdata = wdata;
      end else begin
         ifa.mem_read = rd; ifa.mem_write = wr; ifa.mem_addr = addr; ifa.mem_wdata = wdata;
      end
   endtask

   function automatic logic get_rdy(input bit sel);
      return sel ? ifb.mem_ready : ifa.mem_ready;
   endfunction

   function automatic logic get_busy(input bit sel);
      return sel ? ifb.busy : ifa.busy;
   endfunction

   // One complete access: expected response goes to the scoreboard, latency and busy are timed here.
   task automatic access(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
      int  k;
      int  nbusy;
      bit  seen;
      exp_t e;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      if (sel) q_b.push_back(e); else q_a.push_back(e);
      @(negedge clk);
      set_req(sel, rd, wr, addr, wdata);
      @(posedge clk);
      k = 0; nbusy = 0; seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         k++;
         if (get_rdy(sel) === 1'b1) seen = 1;
         else if (get_busy(sel) === 1'b1) nbusy++;
      end
      set_req(sel, 1'b0, 1'b0, 32'h0, 32'h0);
      if (!seen) begin
         checks++; errors++;
         $display("FAIL ready_timeout addr=%h: no ready within 20 cycles", addr);
      end else begin
         check($sformatf("latency addr=%h", addr), k, exp_lat);
         check($sformatf("busy_cycles addr=%h", addr), nbusy, exp_lat - 1);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (ifa.mem_ready === 1'b1) begin
         if (q_a.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected_ready: got ready expected none");
         end else begin
            e = q_a.pop_front();
            check("a_rdata", ifa.mem_rdata, e.rdata);
            check("a_err", {31'b0, ifa.mem_err}, {31'b0, e.err});
            check("a_busy_with_ready", {31'b0, ifa.busy}, 32'h0);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (ifb.mem_ready === 1'b1) begin
         if (q_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_ready: got ready expected none");
         end else begin
            e = q_b.pop_front();
            check("b_rdata", ifb.mem_rdata, e.rdata);
            check("b_err", {31'b0, ifb.mem_err}, {31'b0, e.err});
            check("b_busy_with_ready", {31'b0, ifb.busy}, 32'h0);
         end
      end
   end

   initial begin
      int   t[3];
      int   n;
      exp_t e;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      #12;
      check("rst_a_rdata", ifa.mem_rdata, 32'h0);
      check("rst_a_flags", {29'b0, ifa.mem_ready, ifa.mem_err, ifa.busy}, 32'h0);
      check("rst_b_flags", {29'b0, ifb.mem_ready, ifb.mem_err, ifb.busy}, 32'h0);
      check("rst_a_state", 32'(u_a.state_q), 32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;

      // Instance A: RL=2, WL=1
      access(0, 0, 1, 32'h80, 32'h2008000A, 32'h0,        0, 1);
      access(0, 1, 0, 32'h80, 32'h0,        32'h2008000A, 0, 2);
      access(0, 0, 1, 32'h84, 32'hDEADBEEF, 32'h2008000A, 0, 1);
      access(0, 1, 0, 32'h84, 32'h0,        32'hDEADBEEF, 0, 2);
      access(0, 0, 1, 32'h10, 32'h12345678, 32'hDEADBEEF, 0, 1);
      access(0, 1, 1, 32'h10, 32'hFFFFFFFF, 32'hDEADBEEF, 1, 2);
      access(0, 1, 0, 32'h10, 32'h0,        32'h12345678, 0, 2);
      access(0, 1, 0, 32'h82, 32'h0,        32'h12345678, 1, 2);
      access(0, 1, 0, 32'h400, 32'h0,       32'h12345678, 1, 2);

      // Instance B: RL=3, WL=3, request held across three reads
      access(1, 0, 1, 32'h20, 32'h000000A1, 32'h0, 0, 3);
      access(1, 0, 1, 32'h24, 32'h000000B2, 32'h0, 0, 3);
      e.err = 1'b0;
      e.rdata = 32'hA1; q_b.push_back(e);
      e.rdata = 32'hB2; q_b.push_back(e);
      e.rdata = 32'hA1; q_b.push_back(e);
      @(negedge clk);
      set_req(1, 1, 0, 32'h20, 32'h0);
      n = 0;
      for (int c = 0; c < 40 && n < 3; c++) begin
         @(negedge clk);
         if (ifb.mem_ready === 1'b1) begin
            t[n] = cyc;
            n++;
            ifb.mem_addr = (n == 1) ? 32'h24 : 32'h20;
         end else if (ifb.busy === 1'b1) begin
            ifb.mem_addr = 32'h1003;
         end
      end
      set_req(1, 0, 0, 32'h0, 32'h0);
      check("held_ready_count", n, 3);
      if (n == 3) begin
         check("held_spacing_1", t[1] - t[0], 4);
         check("held_spacing_2", t[2] - t[1], 4);
      end

      // Reset during a write in BUSY must discard the write
      access(1, 0, 1, 32'h14, 32'h00000055, 32'hA1, 0, 3);
      @(negedge clk);
      set_req(1, 0, 1, 32'h14, 32'h0000AAAA);
      @(posedge clk);
      @(negedge clk);
      check("midrst_busy_before", {31'b0, ifb.busy}, 32'h1);
      set_req(1, 0, 0, 32'h0, 32'h0);
      rst_n = 1'b0;
      #2;
      check("midrst_rdata", ifb.mem_rdata, 32'h0);
      check("midrst_flags", {29'b0, ifb.mem_ready, ifb.mem_err, ifb.busy}, 32'h0);
      check("midrst_state", 32'(u_b.state_q), 32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      access(1, 1, 0, 32'h14, 32'h0, 32'h00000055, 0, 3);

      repeat (3) @(negedge clk);
      check("a_queue_drained", q_a.size(), 0);
      check("b_queue_drained", q_b.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
